// File: rtl/pacman_map_mover_if.sv
// Move-request handshake and grid RAM port shared by the map mover (master)
// and the grid side / requester (slave).
interface pacman_map_mover_if #(
    parameter int XW = 5,
    parameter int YW = 4
);
    logic          move_valid;
    logic [1:0]    move_dir;
    logic          move_ready;
    logic          move_done;
    logic          move_blocked;
    logic [XW-1:0] grid_x;
    logic [YW-1:0] grid_y;
    logic [1:0]    grid_data_in;
    logic [1:0]    grid_data_out;
    logic          grid_readwrite;

    modport master (
        input  move_valid, move_dir, grid_data_out,
        output move_ready, move_done, move_blocked,
        output grid_x, grid_y, grid_data_in, grid_readwrite
    );

    modport slave (
        output move_valid, move_dir, grid_data_out,
        input  move_ready, move_done, move_blocked,
        input  grid_x, grid_y, grid_data_in, grid_readwrite
    );
endinterface

// File: rtl/pacman_map_mover.sv
// Pacman move engine: reads the target grid cell, rejects walls, erases
// pellets with a write-back, and tracks position and score.
module pacman_map_mover #(
    parameter int GRID_W     = 20,
    parameter int GRID_H     = 15,
    parameter int XW         = 5,
    parameter int YW         = 4,
    parameter int START_X    = 1,
    parameter int START_Y    = 1,
    parameter int PELLET_PTS = 10,
    parameter int POWER_PTS  = 50
) (
    input  logic                clock_50,
    input  logic                reset,
    pacman_map_mover_if.master  bus,
    output logic [XW-1:0]       pos_x,
    output logic [YW-1:0]       pos_y,
    output logic [15:0]         score,
    output logic                pellet_eaten
);
    typedef enum logic [2:0] {IDLE, READ, CHECK, WRITE, DONE} state_t;

    state_t        r_state, w_next_state;
    logic [XW-1:0] r_pos_x, r_tgt_x, w_tgt_x;
    logic [YW-1:0] r_pos_y, r_tgt_y, w_tgt_y;
    logic [15:0]   r_score, w_score_next;
    logic [16:0]   w_score_sum;
    logic          r_blocked;
    logic          r_power;

    // Tunnel wrap-around at every grid edge
    always_comb begin
        w_tgt_x = r_pos_x;
        w_tgt_y = r_pos_y;
        case (bus.move_dir)
            2'b00: w_tgt_y = (r_pos_y == '0) ? YW'(GRID_H - 1) : r_pos_y - YW'(1);
            2'b01: w_tgt_x = (r_pos_x == XW'(GRID_W - 1)) ? '0 : r_pos_x + XW'(1);
            2'b10: w_tgt_y = (r_pos_y == YW'(GRID_H - 1)) ? '0 : r_pos_y + YW'(1);
            default: w_tgt_x = (r_pos_x == '0) ? XW'(GRID_W - 1) : r_pos_x - XW'(1);
        endcase
    end

    always_comb begin
        w_score_sum  = {1'b0, r_score} + (r_power ? 17'(POWER_PTS) : 17'(PELLET_PTS));
        w_score_next = w_score_sum[16] ? '1 : w_score_sum[15:0];
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:  if (bus.move_valid) w_next_state = READ;
            READ:  w_next_state = CHECK;
            CHECK: w_next_state = bus.grid_data_out[1] ? WRITE : DONE;
            WRITE: w_next_state = DONE;
            DONE:  w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pos_x   <= XW'(START_X);
            r_pos_y   <= YW'(START_Y);
            r_tgt_x   <= XW'(START_X);
            r_tgt_y   <= YW'(START_Y);
            r_score   <= '0;
            r_blocked <= 1'b0;
            r_power   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: if (bus.move_valid) begin
                    r_tgt_x   <= w_tgt_x;
                    r_tgt_y   <= w_tgt_y;
                    r_blocked <= 1'b0;
                end
                CHECK: begin
                    r_blocked <= (bus.grid_data_out == 2'b01);
                    r_power   <= bus.grid_data_out[0];
                end
                WRITE: r_score <= w_score_next;
                DONE: if (!r_blocked) begin
                    r_pos_x <= r_tgt_x;
                    r_pos_y <= r_tgt_y;
                end
                default: ;
            endcase
        end
    end

    // Strobes decode straight from the state so reset kills a pending write at once
    assign bus.move_ready     = (r_state == IDLE);
    assign bus.move_done      = (r_state == DONE);
    assign bus.move_blocked   = (r_state == DONE) && r_blocked;
    assign bus.grid_readwrite = (r_state == WRITE);
    assign bus.grid_data_in   = '0;
    assign bus.grid_x         = (r_state == IDLE) ? r_pos_x : r_tgt_x;
    assign bus.grid_y         = (r_state == IDLE) ? r_pos_y : r_tgt_y;
    assign pellet_eaten       = (r_state == WRITE);
    assign pos_x              = r_pos_x;
    assign pos_y              = r_pos_y;
    assign score              = r_score;
endmodule

// File: tb/tb_pacman_map_mover.sv
// Directed bench for pacman_map_mover with a behavioural synchronous grid RAM.
module tb_pacman_map_mover;
    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  pos_x;
    logic [3:0]  pos_y;
    logic [15:0] score;
    logic        pellet_eaten;

    logic        mem_clr;
    logic        poke_en;
    logic [4:0]  poke_x;
    logic [3:0]  poke_y;
    logic [1:0]  poke_v;
    logic [1:0]  rdata;
    logic [1:0]  mem [0:14][0:19];

    int checks   = 0;
    int failures = 0;

    pacman_map_mover_if #(.XW(5), .YW(4)) bus ();

    pacman_map_mover #(
        .GRID_W(20), .GRID_H(15), .XW(5), .YW(4),
        .START_X(1), .START_Y(1), .PELLET_PTS(10), .POWER_PTS(50)
    ) dut (
        .clock_50(clk),
        .reset(reset),
        .bus(bus),
        .pos_x(pos_x),
        .pos_y(pos_y),
        .score(score),
        .pellet_eaten(pellet_eaten)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int y = 0; y < 15; y++)
                for (int x = 0; x < 20; x++)
                    mem[y][x] <= 2'b00;
        end else if (poke_en) begin
            mem[poke_y][poke_x] <= poke_v;
        end else if (bus.grid_readwrite && bus.grid_x < 20 && bus.grid_y < 15) begin
            mem[bus.grid_y][bus.grid_x] <= bus.grid_data_in;
        end
        if (bus.grid_x < 20 && bus.grid_y < 15) rdata <= mem[bus.grid_y][bus.grid_x];
        else                                    rdata <= 2'b00;
    end
    assign bus.grid_data_out = rdata;

    task automatic poke(input int x, input int y, input logic [1:0] v);
        poke_x  = 5'(x);
        poke_y  = 4'(y);
        poke_v  = v;
        poke_en = 1'b1;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Starts at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
    task automatic do_move(input logic [1:0] dir, input bit hold_busy,
                           output int lat, output logic blk, output int nwr,
                           output int wr_k, output int npel, output logic [1:0] wdata);
        lat = -1; blk = 1'b0; nwr = 0; wr_k = -1; npel = 0; wdata = 2'b11;
        bus.move_dir   = dir;
        bus.move_valid = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (!hold_busy || k >= 3) bus.move_valid = 1'b0;
            if (bus.grid_readwrite) begin nwr++; wr_k = k; wdata = bus.grid_data_in; end
            if (pellet_eaten) npel++;
            if (bus.move_done) begin lat = k; blk = bus.move_blocked; break; end
        end
        bus.move_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++; if (bus.move_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", bus.move_ready); end
        checks++; if (bus.move_done !== 1'b0 || bus.move_blocked !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b%0b exp=00", bus.move_done, bus.move_blocked); end
        checks++; if (bus.grid_readwrite !== 1'b0 || pellet_eaten !== 1'b0) begin failures++; $display("FAIL reset_rw got=%0b%0b exp=00", bus.grid_readwrite, pellet_eaten); end
        checks++; if (pos_x !== 5'd1 || pos_y !== 4'd1) begin failures++; $display("FAIL reset_pos got=(%0d,%0d) exp=(1,1)", pos_x, pos_y); end
        checks++; if (bus.grid_x !== 5'd1 || bus.grid_y !== 4'd1 || bus.grid_data_in !== 2'b00) begin failures++; $display("FAIL reset_addr got=(%0d,%0d,%0d) exp=(1,1,0)", bus.grid_x, bus.grid_y, bus.grid_data_in); end
        checks++; if (score !== 16'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", score); end
    endtask

    task automatic test_reset_mid_write();
        apply_reset();
        poke(2, 1, 2'b10);
        bus.move_dir   = 2'b01;
        bus.move_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            bus.move_valid = 1'b0;
        end
        checks++; if (bus.grid_readwrite !== 1'b1) begin failures++; $display("FAIL midwr_in_write got=%0b exp=1", bus.grid_readwrite); end
        reset = 1'b1;
        #1;
        checks++; if (bus.grid_readwrite !== 1'b0 || pellet_eaten !== 1'b0) begin failures++; $display("FAIL midwr_rw_drop got=%0b%0b exp=00", bus.grid_readwrite, pellet_eaten); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (mem[1][2] !== 2'b10) begin failures++; $display("FAIL midwr_cell got=%0d exp=2", mem[1][2]); end
        checks++; if (pos_x !== 5'd1 || pos_y !== 4'd1 || score !== 16'd0) begin failures++; $display("FAIL midwr_state got=(%0d,%0d) score=%0d exp=(1,1) score=0", pos_x, pos_y, score); end
        checks++; if (bus.move_ready !== 1'b1) begin failures++; $display("FAIL midwr_ready got=%0b exp=1", bus.move_ready); end
    endtask

    task automatic test_empty();
        int lat, nwr, wk, npel; logic blk; logic [1:0] wd;
        apply_reset();
        poke(2, 1, 2'b00);
        do_move(2'b01, 1'b0, lat, blk, nwr, wk, npel, wd);
        checks++; if (lat !== 3 || blk !== 1'b0) begin failures++; $display("FAIL empty_done got=lat%0d blk%0b exp=lat3 blk0", lat, blk); end
        checks++; if (nwr !== 0 || npel !== 0) begin failures++; $display("FAIL empty_nowrite got=%0d/%0d exp=0/0", nwr, npel); end
        checks++; if (pos_x !== 5'd2 || pos_y !== 4'd1 || score !== 16'd0) begin failures++; $display("FAIL empty_pos got=(%0d,%0d) score=%0d exp=(2,1) score=0", pos_x, pos_y, score); end
    endtask

    task automatic test_wall();
        int lat, nwr, wk, npel; logic blk; logic [1:0] wd;
        apply_reset();
        poke(1, 0, 2'b01);
        do_move(2'b00, 1'b0, lat, blk, nwr, wk, npel, wd);
        checks++; if (lat !== 3 || blk !== 1'b1) begin failures++; $display("FAIL wall_done got=lat%0d blk%0b exp=lat3 blk1", lat, blk); end
        checks++; if (nwr !== 0) begin failures++; $display("FAIL wall_nowrite got=%0d exp=0", nwr); end
        checks++; if (pos_x !== 5'd1 || pos_y !== 4'd1 || mem[0][1] !== 2'b01) begin failures++; $display("FAIL wall_pos got=(%0d,%0d) cell=%0d exp=(1,1) cell=1", pos_x, pos_y, mem[0][1]); end
    endtask

    task automatic test_pellets();
        int lat, nwr, wk, npel; logic blk; logic [1:0] wd;
        apply_reset();
        poke(2, 1, 2'b10);
        poke(3, 1, 2'b11);
        do_move(2'b01, 1'b0, lat, blk, nwr, wk, npel, wd);
        checks++; if (lat !== 4 || blk !== 1'b0) begin failures++; $display("FAIL pellet_done got=lat%0d blk%0b exp=lat4 blk0", lat, blk); end
        checks++; if (nwr !== 1 || wk !== 3 || wd !== 2'b00) begin failures++; $display("FAIL pellet_write got=n%0d k%0d d%0d exp=n1 k3 d0", nwr, wk, wd); end
        checks++; if (npel !== 1) begin failures++; $display("FAIL pellet_pulse got=%0d exp=1", npel); end
        checks++; if (score !== 16'd10 || mem[1][2] !== 2'b00) begin failures++; $display("FAIL pellet_score got=%0d cell=%0d exp=10 cell=0", score, mem[1][2]); end
        checks++; if (pos_x !== 5'd2 || pos_y !== 4'd1) begin failures++; $display("FAIL pellet_pos got=(%0d,%0d) exp=(2,1)", pos_x, pos_y); end
        do_move(2'b01, 1'b0, lat, blk, nwr, wk, npel, wd);
        checks++; if (lat !== 4 || npel !== 1) begin failures++; $display("FAIL power_done got=lat%0d pel%0d exp=lat4 pel1", lat, npel); end
        checks++; if (score !== 16'd60 || mem[1][3] !== 2'b00 || pos_x !== 5'd3) begin failures++; $display("FAIL power_score got=%0d cell=%0d x=%0d exp=60 cell=0 x=3", score, mem[1][3], pos_x); end
    endtask

    task automatic test_tunnel();
        int lat, nwr, wk, npel; logic blk; logic [1:0] wd;
        apply_reset();
        poke(0, 1, 2'b00);
        do_move(2'b11, 1'b0, lat, blk, nwr, wk, npel, wd);
        for (int y = 2; y <= 5; y++) begin
            poke(0, y, 2'b00);
            do_move(2'b10, 1'b0, lat, blk, nwr, wk, npel, wd);
        end
        checks++; if (pos_x !== 5'd0 || pos_y !== 4'd5) begin failures++; $display("FAIL tunnel_setup got=(%0d,%0d) exp=(0,5)", pos_x, pos_y); end
        poke(19, 5, 2'b00);
        do_move(2'b11, 1'b0, lat, blk, nwr, wk, npel, wd);
        checks++; if (pos_x !== 5'd19 || pos_y !== 4'd5) begin failures++; $display("FAIL tunnel_left got=(%0d,%0d) exp=(19,5)", pos_x, pos_y); end
        do_move(2'b01, 1'b0, lat, blk, nwr, wk, npel, wd);
        checks++; if (pos_x !== 5'd0 || pos_y !== 4'd5) begin failures++; $display("FAIL tunnel_right got=(%0d,%0d) exp=(0,5)", pos_x, pos_y); end
        apply_reset();
        poke(1, 0, 2'b00);
        poke(1, 14, 2'b00);
        do_move(2'b00, 1'b0, lat, blk, nwr, wk, npel, wd);
        do_move(2'b00, 1'b0, lat, blk, nwr, wk, npel, wd);
        checks++; if (pos_x !== 5'd1 || pos_y !== 4'd14) begin failures++; $display("FAIL tunnel_up got=(%0d,%0d) exp=(1,14)", pos_x, pos_y); end
        do_move(2'b10, 1'b0, lat, blk, nwr, wk, npel, wd);
        checks++; if (pos_x !== 5'd1 || pos_y !== 4'd0) begin failures++; $display("FAIL tunnel_down got=(%0d,%0d) exp=(1,0)", pos_x, pos_y); end
    endtask

    task automatic test_busy();
        int lat, nwr, wk, npel, extra; logic blk; logic [1:0] wd;
        apply_reset();
        poke(2, 1, 2'b00);
        do_move(2'b01, 1'b1, lat, blk, nwr, wk, npel, wd);
        extra = 0;
        for (int k = 0; k < 8; k++) begin
            if (bus.move_done) extra++;
            @(negedge clk);
        end
        checks++; if (lat !== 3 || extra !== 0) begin failures++; $display("FAIL busy_ignored got=lat%0d extra%0d exp=lat3 extra0", lat, extra); end
        checks++; if (pos_x !== 5'd2 || bus.move_ready !== 1'b1) begin failures++; $display("FAIL busy_pos got=x%0d rdy%0b exp=x2 rdy1", pos_x, bus.move_ready); end
    endtask

    task automatic test_back_to_back();
        int d1, d2, nd;
        apply_reset();
        poke(2, 1, 2'b00);
        poke(3, 1, 2'b00);
        d1 = -1; d2 = -1; nd = 0;
        bus.move_dir   = 2'b01;
        bus.move_valid = 1'b1;
        for (int k = 1; k <= 20 && nd < 2; k++) begin
            @(negedge clk);
            if (bus.move_done) begin
                nd++;
                if (nd == 1) d1 = k;
                else begin d2 = k; bus.move_valid = 1'b0; end
            end
        end
        bus.move_valid = 1'b0;
        @(negedge clk);
        checks++; if (d1 !== 3 || d2 !== 7) begin failures++; $display("FAIL b2b_timing got=%0d,%0d exp=3,7", d1, d2); end
        checks++; if (pos_x !== 5'd3 || pos_y !== 4'd1) begin failures++; $display("FAIL b2b_pos got=(%0d,%0d) exp=(3,1)", pos_x, pos_y); end
    endtask

    task automatic test_saturation();
        int lat, nwr, wk, npel, x; logic blk; logic [1:0] wd;
        apply_reset();
        x = 1;
        for (int i = 0; i < 6553; i++) begin
            x = (x + 1) % 20;
            poke(x, 1, 2'b10);
            do_move(2'b01, 1'b0, lat, blk, nwr, wk, npel, wd);
        end
        checks++; if (score !== 16'd65530 || pos_x !== 5'd14) begin failures++; $display("FAIL sat_preload got=%0d x=%0d exp=65530 x=14", score, pos_x); end
        poke(15, 1, 2'b10);
        do_move(2'b01, 1'b0, lat, blk, nwr, wk, npel, wd);
        checks++; if (score !== 16'hFFFF || npel !== 1) begin failures++; $display("FAIL sat_pellet got=%0d pel=%0d exp=65535 pel=1", score, npel); end
        poke(16, 1, 2'b11);
        do_move(2'b01, 1'b0, lat, blk, nwr, wk, npel, wd);
        checks++; if (score !== 16'hFFFF) begin failures++; $display("FAIL sat_power got=%0d exp=65535", score); end
    endtask

    initial begin
        reset          = 1'b1;
        mem_clr        = 1'b1;
        poke_en        = 1'b0;
        poke_x         = '0;
        poke_y         = '0;
        poke_v         = '0;
        bus.move_valid = 1'b0;
        bus.move_dir   = 2'b00;
        @(negedge clk);
        @(negedge clk);
        mem_clr = 1'b0;
        reset   = 1'b0;
        @(negedge clk);
        test_reset();
        test_reset_mid_write();
        test_empty();
        test_wall();
        test_pellets();
        test_tunnel();
        test_busy();
        test_back_to_back();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
